// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage with registered req/ack data-memory port
// Optional MEM_TIMEOUT_EN: abort a WAIT that lasts TIMEOUT cycles, pulsing mem_err.
module mem_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_memread,
    input  logic        ex_memwrite,
    input  logic [15:0] ex_addr,
    input  logic [15:0] ex_wdata,
    output logic        stall,
    output logic [15:0] memout,
    output logic        memout_valid,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic [15:0] memout_q, memout_d;
    logic        memout_valid_q, memout_valid_d;

    logic        access;
    assign access = ex_valid & (ex_memread | ex_memwrite);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_err_q, mem_err_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_comb begin
        state_d        = state_q;
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        memout_d       = memout_q;
        memout_valid_d = 1'b0;
        stall          = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d          = cnt_q;
        mem_err_d      = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (access) begin
                    stall       = 1'b1;
                    state_d     = S_WAIT;
                    mem_req_d   = 1'b1;
                    // a load+store combination is treated as a store
                    mem_we_d    = ex_memwrite;
                    mem_addr_d  = ex_addr;
                    mem_wdata_d = ex_wdata;
`ifdef MEM_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                if (mem_ack) begin
                    state_d   = S_DONE;
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        memout_d       = mem_rdata;
                        memout_valid_d = 1'b1;
                    end
`ifdef MEM_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d   = S_DONE;
                    mem_req_d = 1'b0;
                    mem_err_d = 1'b1;
                    if (!mem_we_q) begin
                        memout_d       = 16'hFFFF;
                        memout_valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            // EX/MEM still shows the finished instruction here; never restart it
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= 16'h0000;
            mem_wdata_q    <= 16'h0000;
            memout_q       <= 16'h0000;
            memout_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            memout_q       <= memout_d;
            memout_valid_q <= memout_valid_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
        end
    end
    assign mem_err = mem_err_q;
`else
    assign mem_err = 1'b0;
`endif

    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign memout       = memout_q;
    assign memout_valid = memout_valid_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage (timeout cases when MEM_TIMEOUT_EN is defined)
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_memread, ex_memwrite;
    logic [15:0] ex_addr, ex_wdata;
    logic        stall;
    logic [15:0] memout;
    logic        memout_valid;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        mem_err;

    always #5 clk = ~clk;

`ifdef MEM_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    mem_stage #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_memread   (ex_memread),
        .ex_memwrite  (ex_memwrite),
        .ex_addr      (ex_addr),
        .ex_wdata     (ex_wdata),
        .stall        (stall),
        .memout       (memout),
        .memout_valid (memout_valid),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .mem_err      (mem_err)
    );

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } req_t;

    typedef struct packed {
        logic [15:0] memout;
        logic        valid;
        logic        err;
    } rsp_t;

    req_t        req_q[$];
    rsp_t        rsp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_memout = 16'h0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: checks each request when mem_req rises (and while held), each response when stall drops.
    initial begin
        logic prev_stall;
        logic prev_req;
        int   low_run;
        req_t cur;
        rsp_t s;
        prev_stall = 1'b0;
        prev_req   = 1'b0;
        low_run    = 100;
        cur        = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                prev_req   = 1'b0;
                low_run    = 100;
            end else begin
                if (mem_req && !prev_req) begin
                    check("req_gap_ge2", 32'(low_run >= 2), 32'd1);
                    if (req_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL req_unexpected: got request addr 0x%0h, expected none", mem_addr);
                    end else begin
                        cur = req_q.pop_front();
                        check("req_we", 32'(mem_we), 32'(cur.we));
                        check("req_addr", 32'(mem_addr), 32'(cur.addr));
                        check("req_wdata", 32'(mem_wdata), 32'(cur.wdata));
                    end
                end else if (mem_req) begin
                    check("hold_we", 32'(mem_we), 32'(cur.we));
                    check("hold_addr", 32'(mem_addr), 32'(cur.addr));
                    check("hold_wdata", 32'(mem_wdata), 32'(cur.wdata));
                end
                low_run = mem_req ? 0 : low_run + 1;
                if (prev_stall && !stall) begin
                    if (rsp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL rsp_unexpected: got completion memout 0x%0h, expected none", memout);
                    end else begin
                        s = rsp_q.pop_front();
                        check("rsp_memout", 32'(memout), 32'(s.memout));
                        check("rsp_valid", 32'(memout_valid), 32'(s.valid));
                        check("rsp_err", 32'(mem_err), 32'(s.err));
                    end
                end
                prev_stall = stall;
                prev_req   = mem_req;
            end
        end
    end

    // One access; memory acks on WAIT cycle number 'waits' (0 = first WAIT cycle).
    task automatic do_access(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] wd,
                             input int waits, input logic [15:0] rdat,
                             input int exp_stall, input int exp_req, input logic exp_err);
        req_t r;
        rsp_t s;
        int   stall_cnt;
        int   req_cnt;
        int   w;
        bit   done;
        stall_cnt = 0;
        req_cnt   = 0;
        w         = 0;
        done      = 1'b0;
        @(posedge clk);
        #1;
        ex_valid    = 1'b1;
        ex_memread  = rd;
        ex_memwrite = wr;
        ex_addr     = a;
        ex_wdata    = wd;
        r.we = wr; r.addr = a; r.wdata = wd;
        req_q.push_back(r);
        if (!wr) exp_memout = exp_err ? 16'hFFFF : rdat;
        s.memout = exp_memout; s.valid = !wr; s.err = exp_err;
        rsp_q.push_back(s);
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (stall) stall_cnt++;
            if (mem_req) begin
                req_cnt++;
                if (w == waits) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdat;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = 16'h0BAD;
                end
                w++;
            end else begin
                mem_ack = 1'b0;
                if (stall_cnt > 0 && !stall) done = 1'b1;
            end
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL access_timeout: got no completion within 200 cycles, expected stall to fall");
        end
        check("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
        check("req_cycles", 32'(req_cnt), 32'(exp_req));
    endtask

    task automatic idle(input int n, input logic v, input logic rd, input logic wr);
        @(posedge clk);
        #1;
        ex_valid    = v;
        ex_memread  = rd;
        ex_memwrite = wr;
        ex_addr     = 16'h7777;
        ex_wdata    = 16'h8888;
        repeat (n) begin
            @(negedge clk);
            check("idle_stall", 32'(stall), 32'd0);
            check("idle_req", 32'(mem_req), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        ex_valid = 1'b0; ex_memread = 1'b0; ex_memwrite = 1'b0;
        ex_addr = 16'h0; ex_wdata = 16'h0;
        mem_rdata = 16'h0; mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        check("rst_memout", 32'(memout), 32'd0);
        check("rst_memout_valid", 32'(memout_valid), 32'd0);
        check("rst_err", 32'(mem_err), 32'd0);

        idle(3, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b0, 1'b1, 1'b1);

        do_access(1'b1, 1'b0, 16'h0040, 16'h0000, 0, 16'hBEEF, 2, 1, 1'b0);
        idle(2, 1'b0, 1'b0, 1'b0);
        do_access(1'b0, 1'b1, 16'h0010, 16'h1234, 3, 16'h0000, 5, 4, 1'b0);
        idle(1, 1'b0, 1'b0, 1'b0);

        do_access(1'b1, 1'b0, 16'h0100, 16'h0000, 1, 16'h1111, 3, 2, 1'b0);
        do_access(1'b1, 1'b0, 16'h0102, 16'h0000, 0, 16'h2222, 2, 1, 1'b0);
        do_access(1'b1, 1'b1, 16'h0020, 16'h5555, 0, 16'h9999, 2, 1, 1'b0);

        // stray ack while idle must not disturb memout
        @(posedge clk);
        #1;
        ex_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check("stray_memout", 32'(memout), 32'(exp_memout));
        check("stray_valid", 32'(memout_valid), 32'd0);
        check("stray_req", 32'(mem_req), 32'd0);

        // reset in WAIT followed by a late ack
        begin
            req_t r;
            @(posedge clk);
            #1;
            ex_valid = 1'b1; ex_memread = 1'b1; ex_memwrite = 1'b0;
            ex_addr = 16'h0300; ex_wdata = 16'h0000;
            r.we = 1'b0; r.addr = 16'h0300; r.wdata = 16'h0000;
            req_q.push_back(r);
        end
        @(negedge clk);
        @(negedge clk);
        check("wait_req", 32'(mem_req), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1; ex_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hCAFE;
        exp_memout = 16'h0000;
        @(negedge clk);
        check("midrst_req", 32'(mem_req), 32'd0);
        check("midrst_stall", 32'(stall), 32'd0);
        check("midrst_memout", 32'(memout), 32'd0);
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check("lateack_memout", 32'(memout), 32'd0);
        check("lateack_valid", 32'(memout_valid), 32'd0);
        check("lateack_req", 32'(mem_req), 32'd0);

        do_access(1'b1, 1'b0, 16'h0200, 16'h0000, 2, 16'hA5A5, 4, 3, 1'b0);
        idle(1, 1'b0, 1'b0, 1'b0);

`ifdef MEM_TIMEOUT_EN
        do_access(1'b1, 1'b0, 16'h0400, 16'h0000, 1000, 16'h0000, 5, 4, 1'b1);
        idle(1, 1'b0, 1'b0, 1'b0);
        do_access(1'b1, 1'b0, 16'h0402, 16'h0000, 3, 16'h7E57, 5, 4, 1'b0);
        idle(1, 1'b0, 1'b0, 1'b0);
        do_access(1'b0, 1'b1, 16'h0404, 16'h4321, 1000, 16'h0000, 5, 4, 1'b1);
        idle(1, 1'b0, 1'b0, 1'b0);
`endif

        idle(2, 1'b0, 1'b0, 1'b0);
        check("req_queue_empty", 32'(req_q.size()), 32'd0);
        check("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
